spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Sequences byte-wide SPI transfers for the SoC peripheral bus: accepts byte commands, drives sclk/ncs/mosi, samples miso, and returns the received byte.
- Mode 0 (CPOL=0, CPHA=0), MSB first; slaves sample on rising sclk.
- Owns chip-select for up to NUM_CS slaves and keeps ncs asserted across multi-byte transactions until a command marked last.

Parameters:
- NUM_CS, 4, number of chip-select lines (1..8).
- CS_BITS, 2, width of cmd_cs (>= clog2(NUM_CS)).
- DIV_BITS, 8, width of the sclk half-period divider.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_div  in  DIV_BITS  half-period = cfg_div+1 clk cycles; sampled at command accept.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_data  in  8  byte to transmit.
- cmd_cs  in  CS_BITS  target slave index.
- cmd_last  in  1  release ncs after this byte.
- rsp_valid  out  1  one-cycle pulse: byte complete.
- rsp_data  out  8  received byte.
- rsp_err  out  1  valid with rsp_valid; cmd_cs >= NUM_CS.
- sclk  out  1  SPI clock.
- ncs  out  NUM_CS  active-low selects.
- mosi  out  1  master data out.
- miso  in  1  master data in.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; sclk=0, ncs=all 1, mosi=0, rsp_valid=0, rsp_err=0, rsp_data=0, cmd_ready=1 after reset.
  - Applies mid-transfer too: the transfer is aborted and no rsp is produced.
- States: IDLE, XFER, HOLD, GAP.
- cmd_ready: 1 in IDLE and HOLD only.
- Accept occurs when cmd_valid && cmd_ready (cycle T).
  - Latches cmd_data into tx shift register, cmd_cs, cmd_last, and cfg_div into D.
- From IDLE, accept -> XFER. At T+1:
  - ncs[cs]=0; other ncs bits stay 1.
  - mosi=data[7]; sclk=0; half-period counter loads D.
- XFER:
  - Counter decrements each cycle. On reaching 0 it reloads D and sclk toggles.
  - Rising toggle: shift miso into rx LSB.
  - Falling toggle: present the next bit on mosi.
  - 16 toggles per byte (8 rising edges); sclk ends low.
- Completion cycle (after the 16th toggle, exactly T+1+16*(D+1)):
  - rsp_valid=1 for one cycle, rsp_data = rx byte.
  - If last: ncs=all 1, mosi=0, -> IDLE.
  - Else: -> HOLD (ncs held low, sclk 0).
- HOLD, accept:
  - Same cs: -> XFER, counter loads D, mosi=new data[7] at next cycle; no ncs glitch.
  - Different cs: -> GAP with ncs=all 1 for D+1 cycles, then assert the new ncs and -> XFER as from IDLE.
- HOLD with no command: wait indefinitely, ncs stays low.
- cmd_cs >= NUM_CS:
  - Command is accepted and clocked normally, but no ncs bit is asserted.
  - rsp_err=1 with rsp_valid; rsp_data = sampled miso.
- Command inputs are ignored while cmd_ready=0.
- cfg_div changes mid-transfer have no effect until the next accept.
- D=0 is legal: sclk = clk/2.
- Max D gives half-period 2^DIV_BITS cycles.

Decomposition:
- Shared include spi_defs.vh:
  - state encodings (IDLE/XFER/HOLD/GAP);
  - SPI_BITS_PER_BYTE = 8;
  - SPI_TOGGLES_PER_BYTE = 16.
- One sub-module, spi_clkgen: half-period down-counter with load/enable inputs, producing a toggle strobe and a rise/fall indication.
- FSM and shift registers live in spi_master_ctrl.

Test Plan:
- Reset, D=0, send 0xA5 cs=1 last=1, slave model returns 0x3C:
  - mosi bits 1,0,1,0,0,1,0,1 at rising edges; ncs=4'b1101 during the transfer.
  - rsp_valid 17 cycles after accept with rsp_data=0x3C.
  - ncs=4'hF the cycle after.
- D=3, two bytes 0x01 last=0, then 0x80 last=1, cs=2:
  - ncs[2] stays low continuously across both bytes.
  - Each rsp_valid fires 65 cycles after its accept.
  - sclk high/low phases are 4 cycles each.
- HOLD on cs=0, then command cs=3:
  - All ncs high for D+1 cycles, then ncs=4'b0111.
  - No sclk edges during GAP.
- cmd_cs=5 with NUM_CS=4:
  - ncs stays 4'hF; 16 sclk toggles still occur.
  - rsp_err=1 with rsp_valid.
- rst_n=0 after the 3rd rising sclk edge:
  - Next cycle sclk=0, ncs=all 1, no rsp_valid; cmd_ready=1 after release.
  - A new 0xFF transfer completes correctly.
- cmd_valid held high with cmd_ready=0 during XFER:
  - No second accept until completion.
  - Changing cfg_div mid-byte does not alter the sclk period.

Source files
------------

// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master controller: FSM states and byte framing constants.
package spi_master_ctrl_pkg;

  localparam int SPI_BITS_PER_BYTE    = 8;
  localparam int SPI_TOGGLES_PER_BYTE = 16;
  // Wide enough to count 0..SPI_TOGGLES_PER_BYTE-1 sclk toggles.
  localparam int TOG_BITS             = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Command/response bus of the SPI master: byte commands in, received bytes out.
interface spi_master_ctrl_if
  import spi_master_ctrl_pkg::*;
#(
  parameter int CS_BITS = 2
);

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [SPI_BITS_PER_BYTE-1:0] cmd_data;
  logic [CS_BITS-1:0]           cmd_cs;
  logic                         cmd_last;
  logic                         rsp_valid;
  logic [SPI_BITS_PER_BYTE-1:0] rsp_data;
  logic                         rsp_err;

  // Requester side (bus agent issuing commands).
  modport master (
    output cmd_valid, cmd_data, cmd_cs, cmd_last,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_data, cmd_cs, cmd_last,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/spi_clkgen.sv
// Half-period down-counter: strobes once every div+1 enabled cycles and reports
// whether that strobe is a rising or falling sclk edge given the current level.
module spi_clkgen #(
  parameter int DIV_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [DIV_BITS-1:0] div_i,
  input  logic                en_i,
  input  logic                phase_i,
  output logic                tick_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;

  // Tick must not depend on load_i: the controller derives load from tick.
  assign tick_o = en_i && (cnt_q == '0);
  assign rise_o = tick_o && !phase_i;
  assign fall_o = tick_o && phase_i;

  // Next count: explicit load wins, otherwise count down and reload on expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? div_i : cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0, MSB-first SPI master: sequences byte commands, owns chip selects and
// keeps the select low between bytes until a command marked last completes.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int NUM_CS   = 4,
  parameter int CS_BITS  = 2,
  parameter int DIV_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIV_BITS-1:0] cfg_div,
  spi_master_ctrl_if.slave    bus,
  output logic                sclk,
  output logic [NUM_CS-1:0]   ncs,
  output logic                mosi,
  input  logic                miso
);

  state_t                       state_q, state_d;
  logic [SPI_BITS_PER_BYTE-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
  logic [CS_BITS-1:0]           cs_q, cs_d;
  logic [DIV_BITS-1:0]          div_q, div_d;
  logic [TOG_BITS-1:0]          tog_q, tog_d;
  logic [NUM_CS-1:0]            ncs_q, ncs_d;
  logic                         last_q, last_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                         rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

  logic                         cmd_ready, accept, cs_err;
  logic                         cg_load, cg_en, cg_tick, cg_rise, cg_fall;
  logic [DIV_BITS-1:0]          cg_div;
  logic [NUM_CS-1:0]            sel_cmd_n, sel_q_n;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign accept    = bus.cmd_valid && cmd_ready;
  // Out-of-range targets are clocked normally but select nobody and flag an error.
  assign cs_err    = ({1'b0, cs_q} >= (CS_BITS + 1)'(NUM_CS));

  // Active-low one-hot select decodes for the incoming and the latched target.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
    assign sel_cmd_n[gi] = (bus.cmd_cs != CS_BITS'(gi));
    assign sel_q_n[gi]   = (cs_q != CS_BITS'(gi));
  end

  spi_clkgen #(.DIV_BITS(DIV_BITS)) u_clkgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (cg_load),
    .div_i   (cg_div),
    .en_i    (cg_en),
    .phase_i (sclk_q),
    .tick_o  (cg_tick),
    .rise_o  (cg_rise),
    .fall_o  (cg_fall)
  );

  // Next-state and datapath: command latch, select handling, bit shifting, response.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_d        = cs_q;
    last_d      = last_q;
    div_d       = div_q;
    tog_d       = tog_q;
    ncs_d       = ncs_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    cg_load     = 1'b0;
    cg_div      = div_q;
    cg_en       = 1'b0;

    if (accept) begin
      tx_d    = bus.cmd_data;
      cs_d    = bus.cmd_cs;
      last_d  = bus.cmd_last;
      div_d   = cfg_div;
      rx_d    = '0;
      tog_d   = '0;
      sclk_d  = 1'b0;
      cg_load = 1'b1;
      cg_div  = cfg_div;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_XFER;
          ncs_d   = sel_cmd_n;
          mosi_d  = bus.cmd_data[SPI_BITS_PER_BYTE-1];
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (bus.cmd_cs == cs_q) begin
            // Same slave: continue without touching the select.
            state_d = ST_XFER;
            mosi_d  = bus.cmd_data[SPI_BITS_PER_BYTE-1];
          end else begin
            // New slave: deselect everyone for one half-period first.
            state_d = ST_GAP;
            ncs_d   = '1;
          end
        end
      end
      ST_GAP: begin
        cg_en = 1'b1;
        if (cg_tick) begin
          state_d = ST_XFER;
          ncs_d   = sel_q_n;
          mosi_d  = tx_q[SPI_BITS_PER_BYTE-1];
          cg_load = 1'b1;
        end
      end
      ST_XFER: begin
        cg_en = 1'b1;
        if (cg_tick) begin
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 1'b1;
          if (cg_rise) begin
            rx_d = {rx_q[SPI_BITS_PER_BYTE-2:0], miso};
          end
          if (cg_fall) begin
            tx_d   = {tx_q[SPI_BITS_PER_BYTE-2:0], 1'b0};
            mosi_d = tx_q[SPI_BITS_PER_BYTE-2];
          end
          if (tog_q == TOG_BITS'(SPI_TOGGLES_PER_BYTE - 1)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
            rsp_err_d   = cs_err;
            mosi_d      = 1'b0;
            if (last_q) begin
              state_d = ST_IDLE;
              ncs_d   = '1;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer without a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_q        <= '0;
      last_q      <= 1'b0;
      div_q       <= '0;
      tog_q       <= '0;
      ncs_q       <= '1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_q        <= cs_d;
      last_q      <= last_d;
      div_q       <= div_d;
      tog_q       <= tog_d;
      ncs_q       <= ncs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign sclk          = sclk_q;
  assign ncs           = ncs_q;
  assign mosi          = mosi_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed testbench for spi_master_ctrl: a mode-0 slave model plus per-scenario checks.
module tb_spi_master_ctrl;

  localparam int NUM_CS   = 4;
  localparam int CS_BITS  = 3;
  localparam int DIV_BITS = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DIV_BITS-1:0] cfg_div = '0;
  logic                sclk, mosi;
  logic                miso = 1'b0;
  logic [NUM_CS-1:0]   ncs;

  int checks   = 0;
  int failures = 0;

  // Observation results shared by the scenario tasks (single process).
  int         lat, tg, ft, gmin, gmax, nh, no, rc, wc;
  logic [7:0] rd, mb;
  logic       re;

  spi_master_ctrl_if #(.CS_BITS(CS_BITS)) bus ();

  spi_master_ctrl #(
    .NUM_CS   (NUM_CS),
    .CS_BITS  (CS_BITS),
    .DIV_BITS (DIV_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_div (cfg_div),
    .bus     (bus.slave),
    .sclk    (sclk),
    .ncs     (ncs),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  // Issue one byte command (caller is at a negedge) and act as the slave until the
  // response. Observation only; the scenario tasks judge the results.
  task automatic do_xfer(input logic [7:0] data, input logic [CS_BITS-1:0] cs, input logic last,
                         input logic [7:0] sbyte, input logic [3:0] exp_ncs,
                         input logic nxt_en, input logic [7:0] nxt_data, input logic nxt_last,
                         input logic [7:0] nxt_div,
                         output int o_lat, output logic [7:0] o_rd, output logic o_re,
                         output logic [7:0] o_mb, output int o_tg, output int o_ft,
                         output int o_gmin, output int o_gmax, output int o_nh, output int o_no,
                         output int o_rc, output int o_wc);
    int   rises, last_tog;
    logic sclk_prev;
    o_lat = -1; o_rd = '0; o_re = 1'b0; o_mb = '0; o_tg = 0; o_ft = -1;
    o_gmin = 1000000; o_gmax = -1; o_nh = 0; o_no = 0; o_rc = 0; o_wc = 0;
    rises = 0; last_tog = 0; sclk_prev = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_data = data; bus.cmd_cs = cs; bus.cmd_last = last;
    miso = sbyte[7];
    while (bus.cmd_ready !== 1'b1 && o_wc < 2000) begin
      @(negedge clk);
      o_wc++;
    end
    if (o_wc >= 2000) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int n = 1; n <= 5000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (nxt_en) begin
          bus.cmd_data = nxt_data; bus.cmd_last = nxt_last; cfg_div = nxt_div;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (sclk !== sclk_prev) begin
        o_tg++;
        if (o_tg == 1) begin
          o_ft = n;
        end else begin
          if (n - last_tog < o_gmin) o_gmin = n - last_tog;
          if (n - last_tog > o_gmax) o_gmax = n - last_tog;
        end
        last_tog = n;
        if (sclk === 1'b1) begin
          o_mb  = {o_mb[6:0], mosi};
          rises++;
          miso  = (rises < 8) ? sbyte[3'(7 - rises)] : 1'b0;
        end
      end
      sclk_prev = sclk;
      if (bus.rsp_valid === 1'b1) begin
        o_lat = n; o_rd = bus.rsp_data; o_re = bus.rsp_err;
        break;
      end
      if (ncs === 4'hF) o_nh++;
      else if (ncs !== exp_ncs) o_no++;
      if (bus.cmd_ready === 1'b1) o_rc++;
    end
    miso = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_cs = '0; bus.cmd_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (ncs !== 4'hF) begin failures++; $display("FAIL reset_ncs got=%h exp=f", ncs); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
    checks++; if (bus.rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", bus.rsp_data); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    @(negedge clk);
    cfg_div = 8'd0;
    do_xfer(8'hA5, 3'd1, 1'b1, 8'h3C, 4'b1101, 1'b0, 8'h00, 1'b0, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL basic_rsp_data got=%h exp=3c", rd); end
    checks++; if (re !== 1'b0) begin failures++; $display("FAIL basic_rsp_err got=%b exp=0", re); end
    checks++; if (mb !== 8'hA5) begin failures++; $display("FAIL basic_mosi_bits got=%h exp=a5", mb); end
    checks++; if (tg !== 16) begin failures++; $display("FAIL basic_toggles got=%0d exp=16", tg); end
    checks++; if (nh !== 0 || no !== 0) begin failures++; $display("FAIL basic_ncs_during got_hi=%0d got_other=%0d exp=0/0", nh, no); end
    checks++; if (rc !== 0) begin failures++; $display("FAIL basic_ready_busy got=%0d exp=0", rc); end
    @(negedge clk);
    checks++; if (ncs !== 4'hF) begin failures++; $display("FAIL basic_ncs_after got=%h exp=f", ncs); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_rsp_pulse got=%b exp=0", bus.rsp_valid); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL basic_mosi_after got=%b exp=0", mosi); end
    $display("test_basic tx=a5 rx=%h lat=%0d", rd, lat);
  endtask

  task automatic test_multi_byte();
    @(negedge clk);
    cfg_div = 8'd3;
    do_xfer(8'h01, 3'd2, 1'b0, 8'h96, 4'b1011, 1'b0, 8'h00, 1'b0, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (lat !== 65) begin failures++; $display("FAIL multi_lat1 got=%0d exp=65", lat); end
    checks++; if (rd !== 8'h96 || mb !== 8'h01) begin failures++; $display("FAIL multi_data1 got_rx=%h got_tx=%h exp=96/01", rd, mb); end
    checks++; if (gmin !== 4 || gmax !== 4) begin failures++; $display("FAIL multi_phase got_min=%0d got_max=%0d exp=4/4", gmin, gmax); end
    checks++; if (nh !== 0 || no !== 0) begin failures++; $display("FAIL multi_ncs1 got_hi=%0d got_other=%0d exp=0/0", nh, no); end
    checks++; if (ncs !== 4'b1011) begin failures++; $display("FAIL multi_ncs_hold got=%b exp=1011", ncs); end
    do_xfer(8'h80, 3'd2, 1'b1, 8'h69, 4'b1011, 1'b0, 8'h00, 1'b0, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (lat !== 65) begin failures++; $display("FAIL multi_lat2 got=%0d exp=65", lat); end
    checks++; if (rd !== 8'h69 || mb !== 8'h80) begin failures++; $display("FAIL multi_data2 got_rx=%h got_tx=%h exp=69/80", rd, mb); end
    checks++; if (nh !== 0 || no !== 0 || wc !== 0) begin failures++; $display("FAIL multi_ncs2 got_hi=%0d got_other=%0d got_wait=%0d exp=0/0/0", nh, no, wc); end
    @(negedge clk);
    checks++; if (ncs !== 4'hF) begin failures++; $display("FAIL multi_ncs_release got=%h exp=f", ncs); end
    $display("test_multi_byte rx2=%h lat2=%0d", rd, lat);
  endtask

  task automatic test_cs_gap();
    @(negedge clk);
    cfg_div = 8'd1;
    do_xfer(8'h5A, 3'd0, 1'b0, 8'h00, 4'b1110, 1'b0, 8'h00, 1'b0, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL gap_lat_first got=%0d exp=33", lat); end
    @(negedge clk);
    checks++; if (ncs !== 4'b1110 || sclk !== 1'b0) begin failures++; $display("FAIL gap_hold got_ncs=%b got_sclk=%b exp=1110/0", ncs, sclk); end
    do_xfer(8'hC3, 3'd3, 1'b1, 8'hA5, 4'b0111, 1'b0, 8'h00, 1'b0, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (nh !== 2) begin failures++; $display("FAIL gap_deselect_cycles got=%0d exp=2", nh); end
    checks++; if (no !== 0) begin failures++; $display("FAIL gap_ncs_wrong got=%0d exp=0", no); end
    checks++; if (ft !== 5) begin failures++; $display("FAIL gap_first_toggle got=%0d exp=5", ft); end
    checks++; if (lat !== 35) begin failures++; $display("FAIL gap_lat got=%0d exp=35", lat); end
    checks++; if (rd !== 8'hA5 || mb !== 8'hC3) begin failures++; $display("FAIL gap_data got_rx=%h got_tx=%h exp=a5/c3", rd, mb); end
    $display("test_cs_gap rx=%h lat=%0d", rd, lat);
  endtask

  task automatic test_bad_cs();
    @(negedge clk);
    cfg_div = 8'd0;
    do_xfer(8'h0F, 3'd5, 1'b1, 8'h5A, 4'hF, 1'b0, 8'h00, 1'b0, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (nh !== 16 || no !== 0) begin failures++; $display("FAIL badcs_ncs got_hi=%0d got_other=%0d exp=16/0", nh, no); end
    checks++; if (tg !== 16) begin failures++; $display("FAIL badcs_toggles got=%0d exp=16", tg); end
    checks++; if (re !== 1'b1) begin failures++; $display("FAIL badcs_err got=%b exp=1", re); end
    checks++; if (rd !== 8'h5A || lat !== 17) begin failures++; $display("FAIL badcs_data got_rx=%h got_lat=%0d exp=5a/17", rd, lat); end
    $display("test_bad_cs err=%b rx=%h", re, rd);
  endtask

  task automatic test_reset_abort();
    int   rises, pulses;
    logic sp;
    rises = 0; pulses = 0; sp = 1'b0;
    @(negedge clk);
    cfg_div = 8'd1;
    bus.cmd_valid = 1'b1; bus.cmd_data = 8'h55; bus.cmd_cs = 3'd0; bus.cmd_last = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      if (sclk === 1'b1 && sp === 1'b0) rises++;
      sp = sclk;
      if (bus.rsp_valid === 1'b1) pulses++;
      if (rises == 3) break;
    end
    checks++; if (rises !== 3) begin failures++; $display("FAIL abort_reach_rise3 got=%0d exp=3", rises); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (sclk !== 1'b0 || ncs !== 4'hF) begin failures++; $display("FAIL abort_outputs got_sclk=%b got_ncs=%h exp=0/f", sclk, ncs); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", bus.cmd_ready); end
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_no_rsp got=%0d exp=0", pulses); end
    do_xfer(8'hFF, 3'd0, 1'b1, 8'hC3, 4'b1110, 1'b0, 8'h00, 1'b0, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (lat !== 33 || rd !== 8'hC3 || mb !== 8'hFF) begin failures++; $display("FAIL abort_recover got_lat=%0d got_rx=%h got_tx=%h exp=33/c3/ff", lat, rd, mb); end
    $display("test_reset_abort recover rx=%h", rd);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cfg_div = 8'd2;
    // Second command stays valid through the first byte; cfg_div drops to 0 mid-byte.
    do_xfer(8'h3C, 3'd1, 1'b0, 8'h81, 4'b1101, 1'b1, 8'hC3, 1'b1, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (lat !== 49) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=49", lat); end
    checks++; if (rc !== 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d exp=0", rc); end
    checks++; if (gmin !== 3 || gmax !== 3) begin failures++; $display("FAIL b2b_period_kept got_min=%0d got_max=%0d exp=3/3", gmin, gmax); end
    checks++; if (rd !== 8'h81 || mb !== 8'h3C) begin failures++; $display("FAIL b2b_data1 got_rx=%h got_tx=%h exp=81/3c", rd, mb); end
    do_xfer(8'hC3, 3'd1, 1'b1, 8'h7E, 4'b1101, 1'b0, 8'h00, 1'b0, 8'h00,
            lat, rd, re, mb, tg, ft, gmin, gmax, nh, no, rc, wc);
    checks++; if (wc !== 0 || lat !== 17) begin failures++; $display("FAIL b2b_second got_wait=%0d got_lat=%0d exp=0/17", wc, lat); end
    checks++; if (gmin !== 1 || gmax !== 1) begin failures++; $display("FAIL b2b_new_div got_min=%0d got_max=%0d exp=1/1", gmin, gmax); end
    checks++; if (rd !== 8'h7E || mb !== 8'hC3 || nh !== 0 || no !== 0) begin failures++; $display("FAIL b2b_data2 got_rx=%h got_tx=%h got_hi=%0d got_other=%0d exp=7e/c3/0/0", rd, mb, nh, no); end
    $display("test_back_to_back rx2=%h lat2=%0d", rd, lat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_byte();
    test_cs_gap();
    test_bad_cs();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
